// File: rtl/avalon_mem_slave.sv
// avalon_mem_slave: Avalon-MM word memory slave with IDLE/STALL/ACK wait-state sequencing.
// Define AVALON_MEM_RANDOM_STALL_EN to add 0..3 LFSR-driven extra stall cycles per transfer.
module avalon_mem_slave #(
    parameter int          RAM_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'hBFC00000,
    parameter int          STALL_CYCLES = 1,
    parameter              INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        err
);

    localparam int          AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [31:0] RAM_LIM = 32'(RAM_WORDS);
    localparam logic [8:0]  STALL_BASE = 9'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, STALL, ACK} state_t;

    state_t      state_reg, state_next;
    logic [8:0]  cnt_reg, cnt_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;
    logic        is_write_reg;
    logic [31:0] readdata_reg;
    logic        err_reg;

    logic [31:0] mem [RAM_WORDS];

    logic        single_req, both_req, any_req;
    logic        accept, capture_rd, mem_we;
    logic [31:0] cur_addr, word_off;
    logic        cur_is_write, in_range;
    logic [AW-1:0] idx;
    logic [1:0]  extra_stall;
    logic [8:0]  load_val;

    assign single_req = read ^ write;
    assign both_req   = read & write;
    assign any_req    = read | write;
    assign accept     = (state_reg == IDLE) && single_req;

    // In IDLE the decode uses the live bus so a 1-cycle stall can fetch immediately.
    assign cur_addr     = (state_reg == IDLE) ? address : addr_reg;
    assign cur_is_write = (state_reg == IDLE) ? write : is_write_reg;
    assign word_off     = (cur_addr - BASE_ADDR) >> 2;
    assign in_range     = (cur_addr >= BASE_ADDR) && (word_off < RAM_LIM);
    assign idx          = word_off[AW-1:0];

`ifdef AVALON_MEM_RANDOM_STALL_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= 16'hACE1;
        end else if (accept) begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign extra_stall = lfsr_reg[1:0];
`else
    assign extra_stall = 2'd0;
`endif

    assign load_val = STALL_BASE + {7'd0, extra_stall};

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        waitrequest = 1'b0;
        case (state_reg)
            IDLE: begin
                if (single_req) begin
                    waitrequest = 1'b1;
                    cnt_next    = load_val;
                    state_next  = (load_val != 9'd0) ? STALL : ACK;
                end
            end
            STALL: begin
                if (!any_req) begin
                    cnt_next   = 9'd0;
                    state_next = IDLE;
                end else begin
                    waitrequest = 1'b1;
                    cnt_next    = cnt_reg - 9'd1;
                    if (cnt_next == 9'd0) begin
                        state_next = ACK;
                    end
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 9'd0;
            end
        endcase
    end

    assign capture_rd = (state_next == ACK) && (state_reg != ACK) && !cur_is_write;
    assign mem_we     = (state_reg == ACK) && is_write_reg && write && in_range && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 9'd0;
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            be_reg       <= 4'h0;
            is_write_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg     <= address;
                wdata_reg    <= writedata;
                be_reg       <= byteenable;
                is_write_reg <= write;
            end
            // Range errors are flagged at completion so an aborted transfer never sets err.
            if ((state_reg == IDLE && both_req) || (state_reg == ACK && !in_range)) begin
                err_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_reg[i]) begin
                    mem[idx][8*i +: 8] <= wdata_reg[8*i +: 8];
                end
            end
        end
        if (reset) begin
            readdata_reg <= 32'h0;
        end else if (capture_rd) begin
            readdata_reg <= in_range ? mem[idx] : 32'h0;
        end
    end

    assign readdata = readdata_reg;
    assign err      = err_reg;

endmodule
